// File: rtl/booth_csa_seq_mult_pkg.sv
// Shared definitions for the sequential radix-4 Booth / carry-save multiplier:
// digit codes, the Booth recoding function and the FSM state encoding.
package booth_pkg;

    // Multiple of the multiplicand selected by one radix-4 Booth digit
    typedef enum logic [2:0] {
        BOOTH_ZERO = 3'd0,
        BOOTH_P1   = 3'd1,
        BOOTH_P2   = 3'd2,
        BOOTH_N1   = 3'd3,
        BOOTH_N2   = 3'd4
    } booth_code_e;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ACCUM   = 2'd1,
        S_RESOLVE = 2'd2,
        S_DONE    = 2'd3
    } state_e;

    // Recode the overlapping triplet {b[2i+1], b[2i], b[2i-1]} into a digit code
    function automatic booth_code_e booth_encode(input logic [2:0] trip);
        booth_code_e code;
        unique case (trip)
            3'b000, 3'b111: code = BOOTH_ZERO;
            3'b001, 3'b010: code = BOOTH_P1;
            3'b011:         code = BOOTH_P2;
            3'b100:         code = BOOTH_N2;
            3'b101, 3'b110: code = BOOTH_N1;
            default:        code = BOOTH_ZERO;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/booth_csa_seq_mult_if.sv
// Operand / product handshake bundle for booth_csa_seq_mult.
// master = producer of operands and consumer of the product; slave = multiplier.
interface booth_csa_seq_mult_if #(
    parameter int unsigned WIDTH = 16
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   product;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, product
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, product
    );
endinterface

// File: rtl/booth_csa_seq_mult_csa_row.sv
// One row of N independent full-adder cells (3:2 compressor).
// Produces the per-bit sum and the unshifted majority (carry) vector; the
// parent applies the one-bit left shift to the carry.
module csa_row #(
    parameter int unsigned N = 32
) (
    input  logic [N-1:0] x_i,
    input  logic [N-1:0] y_i,
    input  logic [N-1:0] z_i,
    output logic [N-1:0] sum_o,
    output logic [N-1:0] maj_o
);

    for (genvar i = 0; i < N; i++) begin : g_fa
        assign sum_o[i] = x_i[i] ^ y_i[i] ^ z_i[i];
        assign maj_o[i] = (x_i[i] & y_i[i]) | (x_i[i] & z_i[i]) | (y_i[i] & z_i[i]);
    end

endmodule

// File: rtl/booth_csa_seq_mult.sv
// Sequential radix-4 Booth signed multiplier. One Booth digit per cycle is
// folded into a carry-save accumulator; a single carry-propagate add resolves
// the product. Strictly one transaction in flight.
module booth_csa_seq_mult
    import booth_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input logic              clk,
    input logic              rst,
    booth_csa_seq_mult_if.slave bus
);

    localparam int unsigned PW    = 2 * WIDTH;
    localparam int unsigned NDIG  = WIDTH / 2;
    localparam int unsigned CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [PW-1:0]      sum_q, sum_d;
    logic [PW-1:0]      carry_q, carry_d;
    logic [PW-1:0]      product_q, product_d;
    logic               out_valid_q, out_valid_d;

    logic [WIDTH:0]     b_ext;
    logic [2:0]         trip;
    booth_code_e        code;
    logic [PW-1:0]      a_ext;
    logic [PW-1:0]      mult;
    logic [PW-1:0]      pp;
    logic [PW-1:0]      csa_sum;
    logic [PW-1:0]      csa_maj;

    assign bus.in_ready  = (state_q == S_IDLE) && !rst;
    assign bus.out_valid = out_valid_q;
    assign bus.product   = product_q;

    // Booth digit selection and fully formed two's-complement partial product
    always_comb begin
        // Appended zero supplies b[-1] for digit 0
        b_ext = {b_q, 1'b0};
        trip  = 3'(b_ext >> {cnt_q, 1'b0});
        code  = booth_encode(trip);
        a_ext = {{WIDTH{a_q[WIDTH-1]}}, a_q};
        mult  = '0;
        case (code)
            BOOTH_P1:   mult = a_ext;
            BOOTH_P2:   mult = a_ext << 1;
            BOOTH_N1:   mult = -a_ext;
            BOOTH_N2:   mult = -(a_ext << 1);
            default:    mult = '0;
        endcase
        pp = mult << {cnt_q, 1'b0};
    end

    csa_row #(
        .N (PW)
    ) u_csa_row (
        .x_i   (sum_q),
        .y_i   (carry_q),
        .z_i   (pp),
        .sum_o (csa_sum),
        .maj_o (csa_maj)
    );

    // Next-state and datapath updates for the four-phase transaction FSM
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        a_d         = a_q;
        b_d         = b_q;
        sum_d       = sum_q;
        carry_d     = carry_q;
        product_d   = product_q;
        out_valid_d = out_valid_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.in_valid && bus.in_ready) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    sum_d   = '0;
                    carry_d = '0;
                    cnt_d   = '0;
                    state_d = S_ACCUM;
                end
            end
            S_ACCUM: begin
                sum_d   = csa_sum;
                carry_d = {csa_maj[PW-2:0], 1'b0};
                if (cnt_q == CNT_W'(NDIG - 1)) begin
                    state_d = S_RESOLVE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RESOLVE: begin
                product_d   = sum_q + carry_q;
                out_valid_d = 1'b1;
                state_d     = S_DONE;
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any transaction in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            carry_q     <= '0;
            product_q   <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sum_q       <= sum_d;
            carry_q     <= carry_d;
            product_q   <= product_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_booth_csa_seq_mult.sv
// Self-checking bench for booth_csa_seq_mult: directed corner cases, backpressure,
// mid-transaction reset and randomized traffic against a plain a*b reference.
module tb_booth_csa_seq_mult;

    localparam int unsigned W   = 16;
    localparam int unsigned PW  = 2 * W;
    localparam int unsigned LAT = W / 2 + 1;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    booth_csa_seq_mult_if #(.WIDTH(W)) bus ();

    booth_csa_seq_mult #(
        .WIDTH (W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_errs   = 0;
    int n_in     = 0;
    int n_out    = 0;
    int n_done   = 0;

    // Count handshakes as the DUT sees them on each rising edge
    always @(posedge clk) begin
        if (bus.in_valid && bus.in_ready) n_in++;
        if (bus.out_valid && bus.out_ready) n_out++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: signed product reduced modulo 2^(2W)
    function automatic logic [PW-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y);
        logic signed [PW-1:0] sx;
        logic signed [PW-1:0] sy;
        sx = {{W{x[W-1]}}, x};
        sy = {{W{y[W-1]}}, y};
        return sx * sy;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete transaction: optional idle gap, acceptance, wait for product,
    // optional backpressure of bp cycles, output transfer.
    task automatic run_txn(input logic [W-1:0] av, input logic [W-1:0] bv, input int gap,
                           input int bp, input bit chk_lat, input logic [PW-1:0] exp);
        int lat;
        bit seen;
        bus.in_valid = 1'b0;
        repeat (gap) tick();
        bus.in_valid  = 1'b1;
        bus.a         = av;
        bus.b         = bv;
        bus.out_ready = (bp == 0);
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (bus.in_ready) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        if (!seen) begin
            check("in_ready_timeout", 64'd0, 64'd1);
            bus.in_valid = 1'b0;
            return;
        end
        tick();
        bus.in_valid = 1'b0;
        bus.a        = W'($urandom);
        bus.b        = W'($urandom);
        lat  = 0;
        seen = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (bus.out_valid) begin
                lat  = i;
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            check("out_valid_timeout", 64'd0, 64'd1);
            return;
        end
        if (chk_lat) check("latency", 64'(lat), 64'(LAT));
        check("product", 64'(bus.product), 64'(exp));
        if (bp > 0) begin
            for (int i = 0; i < bp; i++) begin
                bus.in_valid = 1'($urandom_range(0, 1));
                bus.a        = W'($urandom);
                bus.b        = W'($urandom);
                tick();
                check("bp_out_valid", 64'(bus.out_valid), 64'd1);
                check("bp_product", 64'(bus.product), 64'(exp));
                check("bp_in_ready", 64'(bus.in_ready), 64'd0);
            end
            bus.in_valid  = 1'b0;
            bus.out_ready = 1'b1;
        end
        tick();
        check("out_valid_after_xfer", 64'(bus.out_valid), 64'd0);
        check("in_ready_after_xfer", 64'(bus.in_ready), 64'd1);
        n_done++;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        bit ov_seen;

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        repeat (2) tick();
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_product", 64'(bus.product), 64'd0);
        check("rst_in_ready", 64'(bus.in_ready), 64'd0);
        rst = 1'b0;
        tick();
        check("post_rst_in_ready", 64'(bus.in_ready), 64'd1);

        // Directed corner cases
        run_txn(16'd3, 16'd5, 0, 0, 1'b1, 32'h0000_000F);
        run_txn(16'h8000, 16'h8000, 0, 0, 1'b1, 32'h4000_0000);
        run_txn(16'h7FFF, 16'h8000, 1, 0, 1'b1, 32'hC000_8000);
        run_txn(16'hFFFF, 16'h0001, 0, 0, 1'b1, 32'hFFFF_FFFF);
        run_txn(16'h1234, 16'h0000, 2, 0, 1'b1, 32'h0000_0000);
        ra = W'($urandom);
        run_txn(ra, 16'h5555, 0, 0, 1'b1, ref_mul(ra, 16'h5555));
        ra = W'($urandom);
        run_txn(ra, 16'hAAAA, 0, 0, 1'b1, ref_mul(ra, 16'hAAAA));
        run_txn(16'h8000, 16'h7FFF, 0, 0, 1'b1, 32'hC000_8000);

        // Backpressure for 5 cycles
        run_txn(16'h0123, 16'hFEDC, 0, 5, 1'b1, ref_mul(16'h0123, 16'hFEDC));

        // Reset while accumulating digit 3
        bus.in_valid  = 1'b1;
        bus.a         = 16'h4321;
        bus.b         = 16'h1357;
        bus.out_ready = 1'b1;
        check("abort_in_ready", 64'(bus.in_ready), 64'd1);
        tick();
        bus.in_valid = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        #1;
        check("abort_rst_in_ready", 64'(bus.in_ready), 64'd0);
        check("abort_rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("abort_rst_product", 64'(bus.product), 64'd0);
        repeat (2) tick();
        rst = 1'b0;
        tick();
        check("abort_release_in_ready", 64'(bus.in_ready), 64'd1);
        ov_seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (bus.out_valid) ov_seen = 1'b1;
        end
        check("abort_no_out_valid", 64'(ov_seen), 64'd0);
        check("abort_product_cleared", 64'(bus.product), 64'd0);
        run_txn(16'd7, 16'hFFF7, 0, 0, 1'b1, 32'hFFFF_FFC1);

        // Randomized traffic with idle gaps and backpressure
        for (int t = 0; t < 2000; t++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            run_txn(ra, rb, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'b1,
                    ref_mul(ra, rb));
        end

        repeat (2) tick();
        check("out_transfers", 64'(n_out), 64'(n_done));
        check("in_transfers", 64'(n_in), 64'(n_done + 1));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
        $finish;
    end

endmodule
